// File: rtl/result_tx.sv
`default_nettype none
// result_tx: debounces the per-frame result code and sends each newly stable code once on a UART-style line. Rev 1.0
// Optional even-parity bit: define RESULT_TX_PARITY_EN.
module result_tx #(
  parameter int STABLE_FRAMES = 3,
  parameter int BIT_CYCLES    = 2500
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] RESULT_IN,
  input  logic       VGA_VSYNC_NEG,
  output logic       TX,
  output logic       BUSY,
  output logic [2:0] CODE_OUT
);

  localparam int            TW     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST  = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] TONE   = TW'(1);
  localparam logic [3:0]    STABLE = 4'(STABLE_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef RESULT_TX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [2:0]    data_q, data_d;
  logic [2:0]    pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [2:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    code_q, code_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          vs_q;
  logic          smp_q;

  logic          match;
  logic [2:0]    cand_nx;
  logic [3:0]    cnt_nx;
  logic          commit;
  logic          bit_end;

  // smp_q marks the cycle after a detected rising edge, when RESULT_IN is taken
  assign match   = (RESULT_IN == cand_q);
  assign cand_nx = match ? cand_q : RESULT_IN;
  assign cnt_nx  = match ? ((cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1) : 4'd1;
  assign commit  = smp_q && (cnt_nx == STABLE) && (cand_nx != code_q);
  assign bit_end = (timer_q == TLAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bidx_q   <= 2'd0;
      data_q   <= 3'd0;
      pend_q   <= 3'd0;
      pend_v_q <= 1'b0;
      cand_q   <= 3'd0;
      cnt_q    <= 4'd0;
      code_q   <= 3'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      vs_q     <= 1'b0;
      smp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bidx_q   <= bidx_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      vs_q     <= VGA_VSYNC_NEG;
      smp_q    <= VGA_VSYNC_NEG & ~vs_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bidx_d   = bidx_q;
    data_d   = data_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    code_d   = code_q;

    if (smp_q) begin
      cand_d = cand_nx;
      cnt_d  = cnt_nx;
    end
    if (commit) begin
      code_d = cand_nx;
    end

    if (state_q == S_IDLE) begin
      if (commit || pend_v_q) begin
        state_d  = S_START;
        timer_d  = '0;
        bidx_d   = 2'd0;
        data_d   = commit ? cand_nx : pend_q;
        pend_v_d = 1'b0;
      end
    end else begin
      // Commits during a frame park in pend; a later one replaces an earlier one
      if (commit) begin
        pend_d   = cand_nx;
        pend_v_d = 1'b1;
      end
      timer_d = bit_end ? '0 : timer_q + TONE;
      if (bit_end) begin
        case (state_q)
          S_START: begin
            state_d = S_DATA;
            bidx_d  = 2'd0;
          end
          S_DATA: begin
            if (bidx_q == 2'd2) begin
`ifdef RESULT_TX_PARITY_EN
              state_d = S_PAR;
`else
              state_d = S_STOP;
`endif
            end else begin
              bidx_d = bidx_q + 2'd1;
            end
          end
`ifdef RESULT_TX_PARITY_EN
          S_PAR: state_d = S_STOP;
`endif
          S_STOP: begin
            if (commit || pend_v_q) begin
              state_d  = S_START;
              data_d   = commit ? cand_nx : pend_q;
              pend_v_d = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Line level is registered from the next state so TX falls one cycle after a commit
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[bidx_d];
`ifdef RESULT_TX_PARITY_EN
      S_PAR:   tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign TX       = tx_q;
  assign BUSY     = busy_q;
  assign CODE_OUT = code_q;

endmodule
`default_nettype wire

// File: tb/tb_result_tx.sv
`default_nettype none
// tb_result_tx: directed and randomized checks of result_tx against a frame-level reference model.
module tb_result_tx;

  localparam int BC = 4;
  localparam int NS = 3;
`ifdef RESULT_TX_PARITY_EN
  localparam int NBITS = 6;
`else
  localparam int NBITS = 5;
`endif
  localparam int FRAME = NBITS * BC;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [2:0] RESULT_IN = 3'd0;
  logic       VGA_VSYNC_NEG = 1'b0;
  logic       TX;
  logic       BUSY;
  logic [2:0] CODE_OUT;

  int n_checks = 0;
  int n_err    = 0;
  int rst_cnt  = 0;
  int tx_lows  = 0;

  logic [2:0] rx_q[$];
  logic [2:0] exp_q[$];
  logic [2:0] hist[$];
  logic [2:0] m_code = 3'd0;

  result_tx #(.STABLE_FRAMES(NS), .BIT_CYCLES(BC)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .RESULT_IN(RESULT_IN),
    .VGA_VSYNC_NEG(VGA_VSYNC_NEG),
    .TX(TX),
    .BUSY(BUSY),
    .CODE_OUT(CODE_OUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge RESET) rst_cnt <= rst_cnt + 1;
  always @(negedge CLK) if (!RESET && TX === 1'b0) tx_lows <= tx_lows + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected line level for serial bit k of a frame carrying code c
  function automatic logic frame_bit(input logic [2:0] c, input int k);
    if (k == 0) return 1'b0;
    if (k <= 3) return c[k-1];
`ifdef RESULT_TX_PARITY_EN
    if (k == 4) return ^c;
`endif
    return 1'b1;
  endfunction

  // One VSYNC rising edge carrying code; the model decides whether it commits
  task automatic vs_edge(input logic [2:0] code, output bit committed);
    int run;
    @(negedge CLK);
    RESULT_IN     = code;
    VGA_VSYNC_NEG = 1'b1;
    @(negedge CLK);
    VGA_VSYNC_NEG = 1'b0;
    hist.push_back(code);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != code) break;
      run++;
    end
    committed = (run == NS) && (code != m_code);
    if (committed) m_code = code;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RESET         = 1'b1;
    VGA_VSYNC_NEG = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    hist.delete();
    m_code = 3'd0;
  endtask

  task automatic compare_rx(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) check(tag, rx_q[i], exp_q[i]);
    rx_q.delete();
    exp_q.delete();
  endtask

  // Serial receiver: samples mid-bit, drops frames interrupted by reset
  initial begin : rx_monitor
    logic [NBITS-1:0] bits;
    int rc;
    forever begin
      @(negedge CLK);
      if (!RESET && TX === 1'b0) begin
        rc   = rst_cnt;
        bits = '0;
        repeat (BC / 2) @(negedge CLK);
        for (int k = 0; k < NBITS; k++) begin
          if (k > 0) repeat (BC) @(negedge CLK);
          bits[k] = TX;
        end
        if (rc == rst_cnt && !RESET) begin
          check("rx_start", bits[0], 1'b0);
`ifdef RESULT_TX_PARITY_EN
          check("rx_parity", bits[4], ^bits[3:1]);
`endif
          check("rx_stop", bits[NBITS-1], 1'b1);
          rx_q.push_back(bits[3:1]);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin : main
    bit         c;
    int         bad;
    int         busy_n;
    int         lows0;
    logic [2:0] code;
    logic [2:0] prev;
    logic [2:0] unst [5];

    // Asynchronous reset, checked before any clock edge
    #2 RESET = 1'b1;
    #1;
    check("rst_tx", TX, 1'b1);
    check("rst_busy", BUSY, 1'b0);
    check("rst_code_out", CODE_OUT, 3'b000);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Basic send of 010 with cycle-exact waveform
    for (int i = 0; i < NS; i++) begin
      vs_edge(3'b010, c);
      if (c) exp_q.push_back(3'b010);
    end
    bad    = 0;
    busy_n = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      @(negedge CLK);
      if (i == 0) check("basic_code_out", CODE_OUT, 3'b010);
      if (TX !== ((i < FRAME) ? frame_bit(3'b010, i / BC) : 1'b1)) bad++;
      if (BUSY === 1'b1) busy_n++;
    end
    check("basic_wave_errs", bad, 0);
    check("basic_busy_cycles", busy_n, FRAME);
    repeat (FRAME) @(negedge CLK);
    compare_rx("basic_rx");

    // Unstable sequence never commits
    apply_reset();
    lows0   = tx_lows;
    unst[0] = 3'b010; unst[1] = 3'b010; unst[2] = 3'b101; unst[3] = 3'b101; unst[4] = 3'b010;
    for (int i = 0; i < 5; i++) begin
      vs_edge(unst[i], c);
      if (c) exp_q.push_back(unst[i]);
      repeat (2) @(negedge CLK);
    end
    repeat (FRAME) @(negedge CLK);
    check("unstable_tx_low_cycles", tx_lows - lows0, 0);
    check("unstable_code_out", CODE_OUT, 3'b000);
    compare_rx("unstable_rx");

    // Long-held code is sent once and the count saturates
    for (int i = 0; i < 20; i++) begin
      vs_edge(3'b110, c);
      if (c) exp_q.push_back(3'b110);
      repeat (FRAME + 6) @(negedge CLK);
    end
    check("hold_cnt_sat", dut.cnt_q, 4'd15);
    check("hold_code_out", CODE_OUT, 3'b110);
    compare_rx("hold_rx");

    // Two commits during a frame: latest follows back-to-back
    for (int i = 0; i < NS; i++) vs_edge(3'b011, c);
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b111);
    busy_n = 0;
    fork
      begin
        for (int i = 0; i < NS; i++) begin vs_edge(3'b100, c); @(negedge CLK); end
        for (int i = 0; i < NS; i++) begin vs_edge(3'b111, c); @(negedge CLK); end
      end
      begin
        for (int i = 0; i < 3 * FRAME; i++) begin
          @(negedge CLK);
          if (BUSY !== 1'b1) break;
          busy_n++;
        end
      end
    join
    check("b2b_busy_cycles", busy_n, 2 * FRAME);
    check("b2b_code_out", CODE_OUT, 3'b111);
    repeat (FRAME) @(negedge CLK);
    compare_rx("b2b_rx");

    // Reset during DATA bit 1, then a clean restart
    for (int i = 0; i < NS; i++) vs_edge(3'b101, c);
    repeat (2 * BC + 2) @(negedge CLK);
    check("mid_pre_rst_tx", TX, 1'b0);
    #2 RESET = 1'b1;
    #1;
    check("mid_rst_tx", TX, 1'b1);
    check("mid_rst_busy", BUSY, 1'b0);
    check("mid_rst_code_out", CODE_OUT, 3'b000);
    @(negedge CLK);
    RESET = 1'b0;
    hist.delete();
    m_code = 3'd0;
    repeat (2 * FRAME) @(negedge CLK);
    for (int i = 0; i < NS; i++) begin
      vs_edge(3'b010, c);
      if (c) exp_q.push_back(3'b010);
    end
    repeat (2 * FRAME) @(negedge CLK);
    check("restart_code_out", CODE_OUT, 3'b010);
    compare_rx("restart_rx");

    // Randomized frames, spaced so every commit is transmitted
    prev = 3'b010;
    for (int i = 0; i < 40; i++) begin
      code = ($urandom_range(0, 9) < 6) ? prev : 3'($urandom_range(0, 7));
      prev = code;
      vs_edge(code, c);
      @(negedge CLK);
      check("rand_code_out", CODE_OUT, m_code);
      if (c) exp_q.push_back(code);
      repeat (FRAME + 6) @(negedge CLK);
    end
    compare_rx("rand_rx");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
